// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-port ALU arbiter.
//   - 4-bit ALU control codes
//   - arbiter FSM state type
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1011;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU.
// Ports:
//   ctrl   in  4      operation code (alu_pkg::ALU_*)
//   a, b   in  WIDTH  operands; shifts use b[4:0] as the amount
//   result out WIDTH  WIDTH-bit result, ADD/SUB wrap with no carry out
//   zero   out 1      result == 0
//   sign   out 1      result MSB
// Undefined codes give result 0 (hence zero=1, sign=0).
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             sign
);

  logic signed [WIDTH-1:0] a_s;
  logic        [4:0]       shamt;

  assign a_s   = a;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SLL: result = a << shamt;
      ALU_XOR: result = a ^ b;
      ALU_SRL: result = a >> shamt;
      ALU_SRA: result = $unsigned(a_s >>> shamt);
      ALU_SUB: result = a - b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign sign = result[WIDTH-1];

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters (port 0: execute stage,
// port 1: address/branch helper) with round-robin arbitration.
// One operation is in flight at a time: IDLE -> EXEC -> RESP.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid[1:0] / req_ready    per-port request handshake
//   req_a0/b0/ctrl0, req_a1/b1/ctrl1  per-port operands and ALU code
//   rsp_valid / rsp_ready         response handshake
//   rsp_id, rsp_result, rsp_zero, rsp_sign  registered response
//   busy                          high whenever not IDLE
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [3:0]       req_ctrl0,
  input  logic [3:0]       req_ctrl1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_sign,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_sign_q, rsp_sign_d;
  logic             rsp_id_q, rsp_id_d;

  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_sign;
  logic [1:0]       grant;

  // One-hot grant. On a tie the port that did not win last time goes.
  function automatic logic [1:0] arb_grant(input logic [1:0] valid,
                                           input logic       last);
    if (valid == 2'b11) return last ? 2'b01 : 2'b10;
    return valid;
  endfunction

  // ALU is driven only from the latched registers, so no request input
  // reaches any response output combinationally.
  alu #(.WIDTH(WIDTH)) u_alu (
    .ctrl   (ctrl_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .zero   (alu_zero),
    .sign   (alu_sign)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    ctrl_d       = ctrl_q;
    id_d         = id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_sign_d   = rsp_sign_q;
    rsp_id_d     = rsp_id_q;
    req_ready    = 2'b00;
    grant        = arb_grant(req_valid, last_grant_q);

    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (grant != 2'b00) begin
          a_d          = grant[1] ? req_a1    : req_a0;
          b_d          = grant[1] ? req_b1    : req_b0;
          ctrl_d       = grant[1] ? req_ctrl1 : req_ctrl0;
          id_d         = grant[1];
          last_grant_d = grant[1];
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_sign_d   = alu_sign;
        rsp_id_d     = id_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_sign_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_sign_q   <= rsp_sign_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  // Latched operands: only meaningful after a handshake, so no reset
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    ctrl_q <= ctrl_d;
    id_q   <= id_d;
  end

  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_sign   = rsp_sign_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter: fixed-cycle scenarios with
// hand-computed expected values.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [3:0]       req_ctrl0 = 4'd0, req_ctrl1 = 4'd0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero, rsp_sign, busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_ctrl0  (req_ctrl0),
    .req_ctrl1  (req_ctrl1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_sign   (rsp_sign),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Present a single-port request in IDLE; returns in the first RESP cycle.
  task automatic issue(input int port, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [3:0] ctrl);
    if (port == 0) begin req_a0 = a; req_b0 = b; req_ctrl0 = ctrl; req_valid = 2'b01; end
    else           begin req_a1 = a; req_b1 = b; req_ctrl1 = ctrl; req_valid = 2'b10; end
    tick();
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rst_req_ready got %b exp 00", req_ready); end
    n_cmp++; if ({rsp_id, rsp_zero, rsp_sign} !== 3'b000) begin n_err++; $display("FAIL rst_rsp_flags got %b exp 000", {rsp_id, rsp_zero, rsp_sign}); end
    n_cmp++; if (rsp_result !== 32'h0) begin n_err++; $display("FAIL rst_rsp_result got %h exp 00000000", rsp_result); end
  endtask

  task automatic test_single_add();
    req_a0 = 32'd5; req_b0 = 32'd3; req_ctrl0 = 4'b0010; rsp_ready = 1'b1;
    req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL add_ready got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    n_cmp++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_exec got busy=%b vld=%b exp busy=1 vld=0", busy, rsp_valid); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL add_rsp_valid got %b exp 1", rsp_valid); end
    n_cmp++; if ({rsp_id, rsp_zero, rsp_sign} !== 3'b000) begin n_err++; $display("FAIL add_flags got %b exp 000", {rsp_id, rsp_zero, rsp_sign}); end
    n_cmp++; if (rsp_result !== 32'd8) begin n_err++; $display("FAIL add_result got %h exp 00000008", rsp_result); end
    tick();
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_done got busy=%b vld=%b exp 0 0", busy, rsp_valid); end
  endtask

  // Both ports request continuously with rsp_ready high: 3-cycle cadence.
  task automatic test_back_to_back();
    logic [1:0]  exp_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_res   [2] = '{32'h0, 32'h0F};
    do_reset();
    req_a0 = 32'd7;  req_b0 = 32'd7;  req_ctrl0 = 4'b0110;
    req_a1 = 32'hFF; req_b1 = 32'h0F; req_ctrl1 = 4'b0000;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (req_ready !== exp_grant[i]) begin n_err++; $display("FAIL rr_grant%0d got %b exp %b", i, req_ready, exp_grant[i]); end
      tick();
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rr_exec_ready%0d got %b exp 00", i, req_ready); end
      tick();
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== exp_grant[i][1]) begin n_err++; $display("FAIL rr_rsp%0d got vld=%b id=%b exp vld=1 id=%b", i, rsp_valid, rsp_id, exp_grant[i][1]); end
      n_cmp++; if (rsp_result !== exp_res[i % 2] || rsp_zero !== (i % 2 == 0)) begin n_err++; $display("FAIL rr_res%0d got %h z=%b exp %h z=%b", i, rsp_result, rsp_zero, exp_res[i % 2], (i % 2 == 0)); end
      tick();
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_hold();
    rsp_ready = 1'b0;
    issue(1, 32'h8000_0000, 32'd4, 4'b1011);
    req_a0 = 32'd1; req_b0 = 32'd1; req_ctrl0 = 4'b0010;
    req_valid = 2'b01;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1) begin n_err++; $display("FAIL hold%0d_vld_id got vld=%b id=%b exp 1 1", i, rsp_valid, rsp_id); end
      n_cmp++; if (rsp_result !== 32'hF800_0000 || rsp_sign !== 1'b1 || rsp_zero !== 1'b0) begin n_err++; $display("FAIL hold%0d_res got %h s=%b z=%b exp f8000000 s=1 z=0", i, rsp_result, rsp_sign, rsp_zero); end
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL hold%0d_ready got %b exp 00", i, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL hold_release_vld got %b exp 1", rsp_valid); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL hold_after got vld=%b busy=%b exp 0 0", rsp_valid, busy); end
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL hold_waiting_ready got %b exp 01", req_ready); end
    req_valid = 2'b00;   // requester withdraws before the edge
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_withdraw_busy got %b exp 0", busy); end
  endtask

  task automatic test_wrap_shift();
    rsp_ready = 1'b0;
    issue(0, 32'd0, 32'd1, 4'b0110);
    n_cmp++; if (rsp_result !== 32'hFFFF_FFFF || rsp_sign !== 1'b1 || rsp_zero !== 1'b0) begin n_err++; $display("FAIL sub_wrap got %h s=%b z=%b exp ffffffff s=1 z=0", rsp_result, rsp_sign, rsp_zero); end
    rsp_ready = 1'b1; tick();
    rsp_ready = 1'b0;
    issue(0, 32'd1, 32'h21, 4'b0011);
    n_cmp++; if (rsp_result !== 32'd2 || rsp_sign !== 1'b0) begin n_err++; $display("FAIL sll_amt got %h s=%b exp 00000002 s=0", rsp_result, rsp_sign); end
    rsp_ready = 1'b1; tick();
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b0;
    // Reset during EXEC
    req_a0 = 32'd5; req_b0 = 32'd3; req_ctrl0 = 4'b0010; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_exec got busy=%b vld=%b exp 0 0", busy, rsp_valid); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_exec_no_rsp%0d got %b exp 0", i, rsp_valid); end
    end
    // Reset during RESP (last grant was port 0 before the reset)
    rsp_ready = 1'b0;
    issue(0, 32'd9, 32'd1, 4'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_result !== 32'h0) begin n_err++; $display("FAIL rst_resp got busy=%b vld=%b res=%h exp 0 0 0", busy, rsp_valid, rsp_result); end
    req_valid = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rst_tie_grant got %b exp 01", req_ready); end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_undef_and_pulse();
    rsp_ready = 1'b0;
    req_a0 = 32'h1234; req_b0 = 32'h5678; req_ctrl0 = 4'b1111; req_valid = 2'b01;
    tick();                       // EXEC
    req_valid = 2'b10;            // one-cycle pulse while busy
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL pulse_ready got %b exp 00", req_ready); end
    tick();                       // RESP
    req_valid = 2'b00;
    n_cmp++; if (rsp_result !== 32'h0 || rsp_zero !== 1'b1 || rsp_sign !== 1'b0 || rsp_id !== 1'b0) begin n_err++; $display("FAIL undef got %h z=%b s=%b id=%b exp 0 z=1 s=0 id=0", rsp_result, rsp_zero, rsp_sign, rsp_id); end
    rsp_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL pulse_no_op%0d got busy=%b vld=%b exp 0 0", i, busy, rsp_valid); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_hold();
    test_wrap_shift();
    test_reset_midflight();
    test_undef_and_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
